// File: rtl/core_mem_fsm.sv
// core_mem_fsm
// Multi-cycle memory sequencer sitting between a RISC-V core datapath and
// valid/ready imem/dmem channels. Each instruction does one fetch, then an
// optional data read or write, then a single non-stalled COMMIT cycle.
// Waiting on a reply can be bounded by TIMEOUT; a timeout forces COMMIT
// and raises bus_err for that cycle.
module core_mem_fsm #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    // core side
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] alu_res,
    input  logic                  we_mem,
    input  logic                  re_mem,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [MASK_WIDTH-1:0] wmask,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  bus_err,

    // instruction fetch channel
    output logic                  imem_r_req_valid,
    input  logic                  imem_r_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_r_req_addr,
    input  logic                  imem_r_rep_valid,
    output logic                  imem_r_rep_ready,
    input  logic [DATA_WIDTH-1:0] imem_r_rep_data,

    // data read channel
    output logic                  dmem_r_req_valid,
    input  logic                  dmem_r_req_ready,
    output logic [ADDR_WIDTH-1:0] dmem_r_req_addr,
    input  logic                  dmem_r_rep_valid,
    output logic                  dmem_r_rep_ready,
    input  logic [DATA_WIDTH-1:0] dmem_r_rep_data,

    // data write channel
    output logic                  dmem_w_req_valid,
    input  logic                  dmem_w_req_ready,
    output logic [ADDR_WIDTH-1:0] dmem_w_req_addr,
    output logic [DATA_WIDTH-1:0] dmem_w_req_data,
    output logic [MASK_WIDTH-1:0] dmem_w_req_mask,
    input  logic                  dmem_w_rep_valid,
    output logic                  dmem_w_rep_ready
);

    // Byte-offset bits dropped from every bus address.
    localparam int OFS = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH - OFS){1'b1}}, {OFS{1'b0}}};

    // Wait counter only needs to reach TIMEOUT.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IF_REQ   = 3'd0,
        IF_WAIT  = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        COMMIT   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      rst_sync;
    logic [1:0]      run_sync;
    logic            rst_n_i;
    logic            run;
    logic            wr_op, rd_op;
    logic            err_q;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            tmo_hit;
    logic            tmo_take;
    logic            ireq_hs, irep_hs;
    logic            mreq_hs, mrep_hs;

    // Reset release synchroniser. Assertion is immediate, release takes two
    // edges. A twin chain drives the output gating so the flop that is used
    // as an asynchronous reset never also feeds clocked data paths.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= '0;
            run_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            run_sync <= {run_sync[0], 1'b1};
        end
    end

    assign rst_n_i = rst_sync[1];
    assign run     = run_sync[1];

    // Handshakes seen this cycle; at most one data channel is ever active.
    assign ireq_hs = imem_r_req_valid & imem_r_req_ready;
    assign irep_hs = imem_r_rep_valid & imem_r_rep_ready;
    assign mreq_hs = (dmem_r_req_valid & dmem_r_req_ready) |
                     (dmem_w_req_valid & dmem_w_req_ready);
    assign mrep_hs = (dmem_r_rep_valid & dmem_r_rep_ready) |
                     (dmem_w_rep_valid & dmem_w_rep_ready);

    // Timeout fires on the TIMEOUT-th wait cycle unless the reply arrives in it.
    assign cnt_inc  = cnt + 1'b1;
    assign tmo_hit  = (TIMEOUT != 0) && (cnt_inc == TMO_C);
    assign tmo_take = tmo_hit &&
                      (((state == IF_WAIT)  && !irep_hs) ||
                       ((state == MEM_WAIT) && !mrep_hs));

    // State register.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) state <= IF_REQ;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IF_REQ: begin
                if (ireq_hs) state_nxt = IF_WAIT;
            end
            IF_WAIT: begin
                if (irep_hs)      state_nxt = (we_mem | re_mem) ? MEM_REQ : COMMIT;
                else if (tmo_hit) state_nxt = COMMIT;
            end
            MEM_REQ: begin
                if (mreq_hs) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mrep_hs || tmo_hit) state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt = IF_REQ;
            end
            default: state_nxt = IF_REQ;
        endcase
    end

    // Handshake and core-facing control outputs, all decoded from state.
    always_comb begin
        imem_r_req_valid = run && (state == IF_REQ);
        imem_r_rep_ready = run && (state == IF_WAIT);
        dmem_r_req_valid = run && (state == MEM_REQ)  && rd_op;
        dmem_w_req_valid = run && (state == MEM_REQ)  && wr_op;
        dmem_r_rep_ready = run && (state == MEM_WAIT) && rd_op;
        dmem_w_rep_ready = run && (state == MEM_WAIT) && wr_op;
        stall            = !(run && (state == COMMIT));
        bus_err          = run && (state == COMMIT) && err_q;
    end

    // Request payloads come straight from the core, which holds them while stalled.
    assign imem_r_req_addr = pc & ALIGN_MASK;
    assign dmem_r_req_addr = alu_res & ALIGN_MASK;
    assign dmem_w_req_addr = alu_res & ALIGN_MASK;
    assign dmem_w_req_data = wdata;
    assign dmem_w_req_mask = wmask;

    // Latch the data operation when leaving fetch; a store wins over a load.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_op <= 1'b0;
            rd_op <= 1'b0;
        end else if ((state == IF_WAIT) && irep_hs) begin
            wr_op <= we_mem;
            rd_op <= re_mem & ~we_mem;
        end
    end

    // Wait-cycle counter: cleared while requesting, counts each wait cycle.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if ((state == IF_WAIT) || (state == MEM_WAIT)) begin
            cnt <= cnt_inc;
        end else begin
            cnt <= '0;
        end
    end

    // Reply data registers; a timed-out reply leaves the old value in place.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inst_data <= '0;
            load_data <= '0;
        end else begin
            if (irep_hs) inst_data <= imem_r_rep_data;
            if (dmem_r_rep_valid && dmem_r_rep_ready) load_data <= dmem_r_rep_data;
        end
    end

    // Timeout flag for the current instruction, reported and cleared in COMMIT.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i)               err_q <= 1'b0;
        else if (tmo_take)          err_q <= 1'b1;
        else if (state == COMMIT)   err_q <= 1'b0;
    end

endmodule

// File: tb/tb_core_mem_fsm.sv
// Bench for core_mem_fsm: directed cases followed by randomized instructions,
// each checked against a per-instruction timing/result model.
module tb_core_mem_fsm;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc, alu_res, wdata;
    logic        we_mem, re_mem;
    logic [7:0]  wmask;
    logic        stall, bus_err;
    logic [63:0] inst_data, load_data;
    logic        imem_r_req_valid, imem_r_req_ready;
    logic [63:0] imem_r_req_addr;
    logic        imem_r_rep_valid, imem_r_rep_ready;
    logic [63:0] imem_r_rep_data;
    logic        dmem_r_req_valid, dmem_r_req_ready;
    logic [63:0] dmem_r_req_addr;
    logic        dmem_r_rep_valid, dmem_r_rep_ready;
    logic [63:0] dmem_r_rep_data;
    logic        dmem_w_req_valid, dmem_w_req_ready;
    logic [63:0] dmem_w_req_addr, dmem_w_req_data;
    logic [7:0]  dmem_w_req_mask;
    logic        dmem_w_rep_valid, dmem_w_rep_ready;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] m_inst = '0;
    logic [63:0] m_load = '0;

    core_mem_fsm #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .MASK_WIDTH(8), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .pc(pc), .alu_res(alu_res), .we_mem(we_mem), .re_mem(re_mem),
        .wdata(wdata), .wmask(wmask),
        .stall(stall), .inst_data(inst_data), .load_data(load_data), .bus_err(bus_err),
        .imem_r_req_valid(imem_r_req_valid), .imem_r_req_ready(imem_r_req_ready),
        .imem_r_req_addr(imem_r_req_addr),
        .imem_r_rep_valid(imem_r_rep_valid), .imem_r_rep_ready(imem_r_rep_ready),
        .imem_r_rep_data(imem_r_rep_data),
        .dmem_r_req_valid(dmem_r_req_valid), .dmem_r_req_ready(dmem_r_req_ready),
        .dmem_r_req_addr(dmem_r_req_addr),
        .dmem_r_rep_valid(dmem_r_rep_valid), .dmem_r_rep_ready(dmem_r_rep_ready),
        .dmem_r_rep_data(dmem_r_rep_data),
        .dmem_w_req_valid(dmem_w_req_valid), .dmem_w_req_ready(dmem_w_req_ready),
        .dmem_w_req_addr(dmem_w_req_addr), .dmem_w_req_data(dmem_w_req_data),
        .dmem_w_req_mask(dmem_w_req_mask),
        .dmem_w_rep_valid(dmem_w_rep_valid), .dmem_w_rep_ready(dmem_w_rep_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] al(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_mem();
        imem_r_req_ready = 1'b0; imem_r_rep_valid = 1'b0;
        dmem_r_req_ready = 1'b0; dmem_r_rep_valid = 1'b0;
        dmem_w_req_ready = 1'b0; dmem_w_rep_valid = 1'b0;
    endtask

    // One instruction from IF_REQ through COMMIT. The bench acts as memory:
    // request ready after bi/bd refused cycles, reply di/dd cycles after acceptance.
    task automatic run_instr(input string tag, input logic [63:0] pc_v,
                             input logic we, input logic re, input logic [63:0] alu,
                             input logic [63:0] wd, input logic [7:0] wm,
                             input int bi, input int di, input int bd, input int dd,
                             input logic [63:0] idat, input logic [63:0] ddat);
        int cyc = 0, at_cyc = 0, iw = 0, dw = 0, iage = 0, dage = 0;
        int n_irep = 0, n_rreq = 0, n_wreq = 0, n_rrep = 0, n_wrep = 0;
        int n_rvld = 0, n_wvld = 0, bad = 0, err_early = 0;
        bit ipend = 0, dpend = 0, done = 0;
        logic err_at = 1'b0;
        logic [63:0] inst_at = '0, load_at = '0;
        bit fetch_ok, mem_op, mem_ok, is_wr, is_rd;
        int exp_cyc;
        logic [63:0] exp_inst, exp_load;

        // reference: cycle budget per phase, timeouts cut a wait at TMO cycles
        fetch_ok = (di <= TMO);
        mem_op   = fetch_ok && (we || re);
        mem_ok   = mem_op && (dd <= TMO);
        is_wr    = mem_op && we;
        is_rd    = mem_op && !we;
        exp_cyc  = (bi + 1) + (fetch_ok ? di : TMO) + 1 +
                   (mem_op ? (bd + 1) + (mem_ok ? dd : TMO) : 0);
        exp_inst = fetch_ok ? idat : m_inst;
        exp_load = (is_rd && mem_ok) ? ddat : m_load;

        pc = pc_v; we_mem = we; re_mem = re; alu_res = alu; wdata = wd; wmask = wm;
        imem_r_rep_data = idat; dmem_r_rep_data = ddat;

        while (!done && cyc < 80) begin
            cyc++;
            imem_r_req_ready = imem_r_req_valid && (iw >= bi);
            if (imem_r_req_valid) iw++;
            dmem_r_req_ready = dmem_r_req_valid && (dw >= bd);
            dmem_w_req_ready = dmem_w_req_valid && (dw >= bd);
            if (dmem_r_req_valid || dmem_w_req_valid) dw++;
            if (ipend) iage++;
            if (dpend) dage++;
            imem_r_rep_valid = ipend && (iage >= di);
            dmem_r_rep_valid = dpend && !we && (dage >= dd);
            dmem_w_rep_valid = dpend && we && (dage >= dd);
            #1;
            if (imem_r_req_valid && imem_r_req_addr !== al(pc_v)) bad++;
            if (dmem_r_req_valid) begin
                n_rvld++;
                if (dmem_r_req_addr !== al(alu)) bad++;
            end
            if (dmem_w_req_valid) begin
                n_wvld++;
                if (dmem_w_req_addr !== al(alu) || dmem_w_req_data !== wd ||
                    dmem_w_req_mask !== wm) bad++;
            end
            if (imem_r_req_valid && imem_r_req_ready) begin ipend = 1; iage = 0; end
            if (imem_r_rep_valid && imem_r_rep_ready) begin ipend = 0; n_irep++; end
            if (dmem_r_req_valid && dmem_r_req_ready) begin dpend = 1; dage = 0; n_rreq++; end
            if (dmem_w_req_valid && dmem_w_req_ready) begin dpend = 1; dage = 0; n_wreq++; end
            if (dmem_r_rep_valid && dmem_r_rep_ready) begin dpend = 0; n_rrep++; end
            if (dmem_w_rep_valid && dmem_w_rep_ready) begin dpend = 0; n_wrep++; end
            if (!stall) begin
                done = 1; at_cyc = cyc; err_at = bus_err;
                inst_at = inst_data; load_at = load_data;
            end else if (bus_err) begin
                err_early++;
            end
            next_cyc();
        end
        idle_mem();

        chk({tag, ".commit_cycle"}, 64'(at_cyc), 64'(exp_cyc));
        chk({tag, ".bus_err"}, 64'(err_at), 64'(!fetch_ok || (mem_op && !mem_ok)));
        chk({tag, ".inst_data"}, inst_at, exp_inst);
        chk({tag, ".load_data"}, load_at, exp_load);
        chk({tag, ".imem_replies"}, 64'(n_irep), 64'(fetch_ok));
        chk({tag, ".rd_req_cycles"}, 64'(n_rvld), 64'(is_rd ? bd + 1 : 0));
        chk({tag, ".wr_req_cycles"}, 64'(n_wvld), 64'(is_wr ? bd + 1 : 0));
        chk({tag, ".rd_reqs"}, 64'(n_rreq), 64'(is_rd));
        chk({tag, ".wr_reqs"}, 64'(n_wreq), 64'(is_wr));
        chk({tag, ".rd_replies"}, 64'(n_rrep), 64'(is_rd && mem_ok));
        chk({tag, ".wr_replies"}, 64'(n_wrep), 64'(is_wr && mem_ok));
        chk({tag, ".req_fields"}, 64'(bad), 64'(0));
        chk({tag, ".err_outside_commit"}, 64'(err_early), 64'(0));
        m_inst = exp_inst;
        m_load = exp_load;
    endtask

    initial begin
        rst = 1'b0;
        pc = '0; alu_res = '0; wdata = '0; wmask = '0; we_mem = 0; re_mem = 0;
        imem_r_rep_data = '0; dmem_r_rep_data = '0;
        idle_mem();
        repeat (2) @(negedge clk);
        #1;
        chk("reset.stall", 64'(stall), 64'(1));
        chk("reset.imem_req_valid", 64'(imem_r_req_valid), 64'(0));
        chk("reset.readys", 64'({imem_r_rep_ready, dmem_r_rep_ready, dmem_w_rep_ready}), 64'(0));
        chk("reset.dmem_valids", 64'({dmem_r_req_valid, dmem_w_req_valid}), 64'(0));
        chk("reset.inst_data", inst_data, 64'(0));
        chk("reset.load_data", load_data, 64'(0));
        chk("reset.bus_err", 64'(bus_err), 64'(0));

        // release: request appears after the second rising edge
        @(negedge clk);
        rst = 1'b1;
        next_cyc();
        chk("release.edge1_valid", 64'(imem_r_req_valid), 64'(0));
        next_cyc();
        chk("release.edge2_valid", 64'(imem_r_req_valid), 64'(1));

        // ALU-only program, zero-wait memory
        run_instr("alu0", 64'h0, 0, 0, 64'h0, 64'h0, 8'h00, 0, 1, 0, 1, 64'h0000_0013_0000_0093, 64'h0);
        run_instr("alu1", 64'h4, 0, 0, 64'h0, 64'h0, 8'h00, 0, 1, 0, 1, 64'h1111_2222_3333_4444, 64'h0);
        run_instr("alu2", 64'h8, 0, 0, 64'h0, 64'h0, 8'h00, 0, 1, 0, 1, 64'h5555_6666_7777_8888, 64'h0);
        // load
        run_instr("load", 64'hC, 0, 1, 64'h1008, 64'h0, 8'h00, 0, 1, 0, 1,
                  64'h0000_3003_0000_0003, 64'hDEAD_BEEF_0000_0001);
        // store with 3 cycles of request backpressure
        run_instr("store", 64'h10, 1, 0, 64'h2004, 64'h1234_5678, 8'h0F, 0, 1, 3, 1,
                  64'h0000_0023_0000_0023, 64'h0);
        // both flags: write wins, load_data untouched
        run_instr("st_ld", 64'h18, 1, 1, 64'h2010, 64'hCAFE_F00D, 8'hF0, 1, 2, 1, 2,
                  64'h0000_00A3_0000_00A3, 64'hBAD0_BAD0_BAD0_BAD0);
        // fetch timeout
        run_instr("timeout", 64'h20, 0, 1, 64'h3000, 64'h0, 8'h00, 0, 99, 0, 1,
                  64'hFFFF_0000_FFFF_0000, 64'h0);
        // late reply after the timeout must not be consumed
        imem_r_rep_data = 64'h0BAD_0BAD_0BAD_0BAD;
        imem_r_rep_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("late_reply.rep_ready", 64'(imem_r_rep_ready), 64'(0));
            next_cyc();
        end
        idle_mem();
        chk("late_reply.inst_data", inst_data, m_inst);

        // randomized instruction mix
        for (int n = 0; n < 24; n++) begin
            int op;
            op = $urandom_range(0, 3);
            run_instr("rand", {32'h0, $urandom} & 64'hFFFF_FFFC, op[1], op[0],
                      {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                      $urandom_range(0, 2), $urandom_range(1, 5),
                      $urandom_range(0, 2), $urandom_range(1, 5),
                      {$urandom, $urandom}, {$urandom, $urandom});
        end

        // reset in MEM_WAIT of a load
        pc = 64'h2000; we_mem = 0; re_mem = 1; alu_res = 64'h3010;
        imem_r_req_ready = 1'b1;
        next_cyc();
        imem_r_req_ready = 1'b0;
        imem_r_rep_valid = 1'b1; imem_r_rep_data = 64'hA5A5_A5A5_A5A5_A5A5;
        next_cyc();
        imem_r_rep_valid = 1'b0;
        dmem_r_req_ready = 1'b1;
        #1;
        chk("midrst.rd_req_valid", 64'(dmem_r_req_valid), 64'(1));
        next_cyc();
        dmem_r_req_ready = 1'b0;
        #1;
        chk("midrst.rd_rep_ready_before", 64'(dmem_r_rep_ready), 64'(1));
        rst = 1'b0;
        #1;
        chk("midrst.rd_rep_ready", 64'(dmem_r_rep_ready), 64'(0));
        chk("midrst.stall", 64'(stall), 64'(1));
        chk("midrst.inst_data", inst_data, 64'(0));
        chk("midrst.load_data", load_data, 64'(0));
        dmem_r_rep_valid = 1'b1; dmem_r_rep_data = 64'h57A1_E5A1_E5A1_E5A1;
        next_cyc();
        rst = 1'b1;
        next_cyc();
        chk("midrst.edge1_rep_ready", 64'(dmem_r_rep_ready), 64'(0));
        chk("midrst.edge1_valid", 64'(imem_r_req_valid), 64'(0));
        next_cyc();
        chk("midrst.edge2_valid", 64'(imem_r_req_valid), 64'(1));
        chk("midrst.refetch_addr", imem_r_req_addr, 64'h2000);
        chk("midrst.edge2_rep_ready", 64'(dmem_r_rep_ready), 64'(0));
        idle_mem();
        m_inst = '0;
        m_load = '0;
        run_instr("refetch", 64'h2000, 0, 1, 64'h3010, 64'h0, 8'h00, 0, 1, 0, 1,
                  64'h0000_2003_0000_2003, 64'h0123_4567_89AB_CDEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_mem_fsm.md
Name: core_mem_fsm

Overview:
- Multi-cycle memory sequencer between a RISC-V core datapath and the Mem_ift valid/ready memory channels.
- Per instruction it fetches from imem, then performs an optional dmem read or write, and holds the core stalled until all transactions complete.
- It replaces the fixed zero-latency memory assumption with parametrised widths and handshakes, a bounded wait timeout, and error reporting.

Parameters:
ADDR_WIDTH, 64, width of pc and data address.
DATA_WIDTH, 64, memory bus width in bits; must be a power of two, at least 32.
MASK_WIDTH, DATA_WIDTH/8, byte write-mask width.
TIMEOUT, 0, maximum cycles spent in any WAIT state; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
pc  in  ADDR_WIDTH  fetch address, sampled in IF_REQ
alu_res  in  ADDR_WIDTH  data address, sampled in MEM_REQ
we_mem  in  1  current instruction stores
re_mem  in  1  current instruction loads
wdata  in  DATA_WIDTH  store data, pre-aligned
wmask  in  MASK_WIDTH  store byte mask
stall  out  1  core must hold pc and register writes
inst_data  out  DATA_WIDTH  latched imem reply
load_data  out  DATA_WIDTH  latched dmem read reply
bus_err  out  1  one-cycle pulse in COMMIT if a timeout occurred for this instruction
imem_r_req_valid / imem_r_req_ready / imem_r_req_addr  out/in/out  1/1/ADDR_WIDTH  fetch request
imem_r_rep_valid / imem_r_rep_ready / imem_r_rep_data  in/out/in  1/1/DATA_WIDTH  fetch reply
dmem_r_req_valid / dmem_r_req_ready / dmem_r_req_addr  out/in/out  1/1/ADDR_WIDTH
dmem_r_rep_valid / dmem_r_rep_ready / dmem_r_rep_data  in/out/in  1/1/DATA_WIDTH
dmem_w_req_valid / dmem_w_req_ready  out/in  1/1
dmem_w_req_addr / dmem_w_req_data / dmem_w_req_mask  out  ADDR_WIDTH/DATA_WIDTH/MASK_WIDTH
dmem_w_rep_valid / dmem_w_rep_ready  in/out  1/1

Behaviour:
- States: IF_REQ, IF_WAIT, MEM_REQ, MEM_WAIT, COMMIT.
- Reset (rst=0, asynchronous):
  - state=IF_REQ, all valid/ready outputs 0, inst_data=0, load_data=0, bus_err=0, stall=1, timeout counter=0.
  - Deassertion is synchronised internally; the first IF_REQ request issues on the second rising edge after rst rises.
  - Reset mid-transaction abandons the transaction; no reply is consumed afterwards until a new request is issued.
- IF_REQ:
  - imem_r_req_valid=1, addr={pc[ADDR_WIDTH-1:log2(DATA_WIDTH/8)], zeros}.
  - valid and addr stay stable until ready; on valid&ready go to IF_WAIT.
- IF_WAIT:
  - imem_r_rep_ready=1; on rep_valid latch inst_data.
  - Then go to MEM_REQ if we_mem|re_mem, else COMMIT.
- MEM_REQ:
  - re_mem only: dmem_r_req_valid=1, addr=alu_res aligned as above.
  - we_mem: dmem_w_req_valid=1 with addr/data/mask. we_mem has priority when both we_mem and re_mem are 1 (no read issued).
  - Outputs hold until ready, then go to MEM_WAIT.
- MEM_WAIT:
  - Ready asserted on the matching reply channel only; load_data latched on dmem_r_rep_valid.
  - Write-reply data is ignored; the reply itself is awaited before proceeding.
  - Then go to COMMIT.
- Reply timing: replies are accepted only in WAIT states. Memory replies no earlier than the cycle after request acceptance.
- COMMIT:
  - stall=0 for exactly one cycle; core updates pc and register file.
  - Next state IF_REQ. stall=1 in every other state.
- Timeout:
  - Counter clears on each WAIT entry and increments per WAIT cycle.
  - If TIMEOUT!=0 and counter reaches TIMEOUT, force COMMIT. The missing data register keeps its old value.
  - bus_err=1 during that COMMIT.
  - Late replies arriving afterwards are dropped (ready=0).
- Latency with always-ready, next-cycle-reply memory: 3 cycles per non-memory instruction, 5 per load/store.
- pc, we_mem, re_mem and alu_res must be stable while stall=1. The block does not re-sample them after entering the corresponding REQ state.

Test Plan:
- Zero-wait memory, ALU-only program at pc=0 → imem_r_req_addr=0,4-aligned words fetched; stall low on cycles 3,6,9; bus_err never set.
- Load with alu_res=0x1008, dmem rdata=0xDEAD_BEEF_0000_0001 → dmem_r_req_addr=0x1008, load_data=0xDEADBEEF00000001 in COMMIT, stall low once after 5 cycles.
- Store with we_mem=1, wmask=0x0F, wdata=0x12345678 and 3-cycle ready backpressure → w_req fields stable for all 3 cycles; one write issued; no dmem read valid.
- we_mem=re_mem=1 → only the write channel is used; load_data unchanged.
- TIMEOUT=4, imem never replies → COMMIT after 4 IF_WAIT cycles with bus_err=1 for one cycle; a reply 2 cycles later is not accepted.
- rst pulled low during MEM_WAIT → outputs immediately at reset values; after release the FSM refetches from the current pc.
